rtt_probe_gen: RTL



---
 rtl/rtt_probe_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rtt_probe_gen.sv
// RTT probe frame source: builds 64-byte Ethernet probe frames (seq + launch timestamp)
// and streams them over a data/ctrl/wr/rdy writer port. Define RTT_PROBE_HDR_EN to emit the module header word.
module rtt_probe_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0002_0000_0001,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter logic [15:0] DST_PORT   = 16'h0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           period,
  input  logic                  start,
  input  logic [63:0]           count64,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic [31:0]           probe_seq,
  output logic                  probe_sent,
  output logic                  overrun,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;

`ifdef RTT_PROBE_HDR_EN
  localparam state_t LAUNCH_STATE = HDR;
`else
  localparam state_t LAUNCH_STATE = BODY;
`endif

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [63:0] ts_reg;
  logic        pending;
  logic [31:0] timer;
  logic        enable_q;
  logic        en_rise, expire, req, launch;

  // Handshake: a word transfers on every cycle where out_wr is high; out_wr is
  // busy && out_rdy, and data/ctrl only advance on a transfer so they hold during stalls.
  assign en_rise    = enable & ~enable_q;
  assign expire     = enable & enable_q & (period != 32'd0) & (timer == 32'd1);
  assign req        = start | expire;
  assign busy       = (state != IDLE);
  assign out_wr     = busy & out_rdy;
  assign launch     = (state == IDLE) & (req | pending);
  assign probe_sent = (state == BODY) & (idx == 3'd7) & out_wr;
  assign overrun    = req & pending;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = LAUNCH_STATE;
      HDR:     if (out_wr) state_nxt = BODY;
      BODY:    if (out_wr && idx == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    out_ctrl = '0;
    case (state)
      HDR: begin
        out_ctrl = '1;
        out_data = {DST_PORT, 16'd8, 16'd0, 16'd64};
      end
      BODY: begin
        case (idx)
          3'd0:    out_data = {DST_MAC, SRC_MAC[47:32]};
          3'd1:    out_data = {SRC_MAC[31:0], ETHERTYPE, probe_seq[31:16]};
          3'd2:    out_data = {probe_seq[15:0], ts_reg[63:16]};
          3'd3:    out_data = {ts_reg[15:0], 48'h0};
          default: out_data = '0;
        endcase
        if (idx == 3'd7) out_ctrl = CTRL_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Timer sits at the reload value whenever it cannot run, so a rising enable starts a full period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer    <= '0;
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;
      if (!enable || period == 32'd0 || en_rise || expire) timer <= period;
      else                                                  timer <= timer - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_reg    <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      probe_seq <= '0;
    end else begin
      if (launch) begin
        ts_reg  <= count64;
        idx     <= '0;
        pending <= 1'b0;
      end else if (req && busy && !pending) begin
        pending <= 1'b1;
      end
      if (state == BODY && out_wr) idx <= idx + 3'd1;
      if (probe_sent) probe_seq <= probe_seq + 32'd1;
    end
  end

endmodule
